// File: rtl/seq_alu.sv
// Registered, handshaked ALU with 6502-style binary/decimal ADC/SBC, logic, shift and compare ops.
// A decimal ADC/SBC spends one extra cycle (DADJ) applying the nibble correction to the binary result.
module seq_alu #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             overflow_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             negative,
    output logic             overflow,
    output logic             zero,
    output logic             carry
);

    localparam int NIB = WIDTH / 4;

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_SBC = 4'h1;
    localparam logic [3:0] OP_EOR = 4'h2;
    localparam logic [3:0] OP_ORA = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_DEC = 4'h6;
    localparam logic [3:0] OP_ROR = 4'h7;
    localparam logic [3:0] OP_ROL = 4'h8;
    localparam logic [3:0] OP_ASL = 4'h9;
    localparam logic [3:0] OP_LSR = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;

    typedef enum logic [1:0] {IDLE, EXEC, DADJ, DONE} state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_dec_p0;

    logic [3:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             cin_p0;
    logic             vin_p0;
    logic             dec_p0;

    logic [WIDTH-1:0] ar_p1;
    logic [NIB-1:0]   nc_p1;
    logic             arc_p1;
    logic             sub_p1;
    logic             cy_p1;
    logic [3:0]       bn_p1;
    logic [4:0]       t5_p1;
    logic [WIDTH-1:0] f_p1;
    logic             c_p1;
    logic             v_p1;

    logic [NIB-1:0]   nc_p2;
    logic [WIDTH:0]   fix_p2;

    // ADC correction: a nibble above 9 (after any carry added by the nibble below) or one that
    // carried in the binary add gets +6; only carries not already taken in binary ripple upward.
    function automatic logic [WIDTH:0] bcd_add_fix(input logic [WIDTH-1:0] bin,
                                                   input logic [NIB-1:0]   nc);
        logic [WIDTH-1:0] r;
        logic [4:0]       x;
        logic             cadd;
        logic             dc;
        r    = bin;
        cadd = 1'b0;
        dc   = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            x    = {1'b0, bin[4*i +: 4]} + {4'd0, cadd};
            dc   = nc[i] | (x > 5'd9);
            x    = x + (dc ? 5'd6 : 5'd0);
            r[4*i +: 4] = x[3:0];
            cadd = dc & ~nc[i];
        end
        return {dc, r};
    endfunction

    // SBC correction: borrows already ripple identically in binary and BCD, so each borrowing
    // nibble just drops by 6 to turn its +16 wrap into a +10 wrap.
    function automatic logic [WIDTH:0] bcd_sub_fix(input logic [WIDTH-1:0] bin,
                                                   input logic [NIB-1:0]   nb);
        logic [WIDTH-1:0] r;
        r = bin;
        for (int i = 0; i < NIB; i++) begin
            if (nb[i]) begin
                r[4*i +: 4] = bin[4*i +: 4] - 4'd6;
            end
        end
        return {~nb[NIB-1], r};
    endfunction

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign is_dec_p0 = (DECIMAL_EN != 0) && dec_p0 && (op_p0 == OP_ADC || op_p0 == OP_SBC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = is_dec_p0 ? DADJ : DONE;
            DADJ: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p0: operands captured at the accept edge ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= op;
            a_p0   <= a;
            b_p0   <= b;
            cin_p0 <= carry_in;
            vin_p0 <= overflow_in;
            dec_p0 <= decimal;
        end
    end

    // ---- p1: EXEC, nibble-rippled add/subtract keeps the per-nibble carries for DADJ ----
    always_comb begin
        ar_p1  = '0;
        nc_p1  = '0;
        bn_p1  = '0;
        t5_p1  = '0;
        sub_p1 = (op_p0 == OP_SBC) || (op_p0 == OP_CMP);
        cy_p1  = (op_p0 == OP_CMP) ? 1'b1 : cin_p0;
        for (int i = 0; i < NIB; i++) begin
            bn_p1 = sub_p1 ? ~b_p0[4*i +: 4] : b_p0[4*i +: 4];
            t5_p1 = {1'b0, a_p0[4*i +: 4]} + {1'b0, bn_p1} + {4'd0, cy_p1};
            ar_p1[4*i +: 4] = t5_p1[3:0];
            cy_p1    = t5_p1[4];
            nc_p1[i] = sub_p1 ? ~t5_p1[4] : t5_p1[4];
        end
        arc_p1 = cy_p1;
    end

    always_comb begin
        f_p1 = a_p0;
        c_p1 = cin_p0;
        v_p1 = vin_p0;
        case (op_p0)
            OP_ADC: begin
                f_p1 = ar_p1;
                c_p1 = arc_p1;
                v_p1 = ~(a_p0[WIDTH-1] ^ b_p0[WIDTH-1]) & (a_p0[WIDTH-1] ^ ar_p1[WIDTH-1]);
            end
            OP_SBC: begin
                f_p1 = ar_p1;
                c_p1 = arc_p1;
                v_p1 = (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]) & (a_p0[WIDTH-1] ^ ar_p1[WIDTH-1]);
            end
            OP_EOR: f_p1 = a_p0 ^ b_p0;
            OP_ORA: f_p1 = a_p0 | b_p0;
            OP_AND: f_p1 = a_p0 & b_p0;
            OP_INC: f_p1 = a_p0 + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_DEC: f_p1 = a_p0 - {{(WIDTH-1){1'b0}}, 1'b1};
            OP_ROR: begin
                f_p1 = {cin_p0, b_p0[WIDTH-1:1]};
                c_p1 = b_p0[0];
            end
            OP_ROL: begin
                f_p1 = {b_p0[WIDTH-2:0], cin_p0};
                c_p1 = b_p0[WIDTH-1];
            end
            OP_ASL: begin
                f_p1 = {b_p0[WIDTH-2:0], 1'b0};
                c_p1 = b_p0[WIDTH-1];
            end
            OP_LSR: begin
                f_p1 = {1'b0, b_p0[WIDTH-1:1]};
                c_p1 = b_p0[0];
            end
            OP_CMP: begin
                f_p1 = ar_p1;
                c_p1 = arc_p1;
            end
            default: begin
                f_p1 = a_p0;
                c_p1 = 1'b0;
            end
        endcase
    end

    // ---- p2: DADJ, decimal correction of the binary result held in f ----
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            nc_p2 <= nc_p1;
        end
    end

    assign fix_p2 = (op_p0 == OP_SBC) ? bcd_sub_fix(f, nc_p2) : bcd_add_fix(f, nc_p2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f        <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else if (state == EXEC) begin
            f        <= f_p1;
            negative <= f_p1[WIDTH-1];
            overflow <= v_p1;
            zero     <= (f_p1 == '0);
            carry    <= c_p1;
        end else if (state == DADJ) begin
            f        <= fix_p2[WIDTH-1:0];
            negative <= fix_p2[WIDTH-1];
            zero     <= (fix_p2[WIDTH-1:0] == '0);
            carry    <= fix_p2[WIDTH];
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: three instances (8-bit decimal, 16-bit decimal, 8-bit binary-only) run in
// lockstep against a plain-arithmetic reference model, plus directed handshake and reset cases.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  op_i = '0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        vin_i = 1'b0;
    logic        dec_i = 1'b0;

    logic        ir0, ov0, n0, v0, z0, c0;
    logic [7:0]  f0;
    logic        ir1, ov1, n1, v1, z1, c1;
    logic [15:0] f1;
    logic        ir2, ov2, n2, v2, z2, c2;
    logic [7:0]  f2;

    int n_chk = 0;
    int n_err = 0;

    longint cf[3];
    bit     cn[3], cvv[3], cz[3], cc[3];
    int     clat[3];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8), .DECIMAL_EN(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .op(op_i),
        .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin_i), .overflow_in(vin_i), .decimal(dec_i),
        .out_valid(ov0), .out_ready(out_ready), .f(f0), .negative(n0), .overflow(v0),
        .zero(z0), .carry(c0));

    seq_alu #(.WIDTH(16), .DECIMAL_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .op(op_i),
        .a(a_i), .b(b_i), .carry_in(cin_i), .overflow_in(vin_i), .decimal(dec_i),
        .out_valid(ov1), .out_ready(out_ready), .f(f1), .negative(n1), .overflow(v1),
        .zero(z1), .carry(c1));

    seq_alu #(.WIDTH(8), .DECIMAL_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .op(op_i),
        .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin_i), .overflow_in(vin_i), .decimal(dec_i),
        .out_valid(ov2), .out_ready(out_ready), .f(f2), .negative(n2), .overflow(v2),
        .zero(z2), .carry(c2));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint pow10(input int nd);
        longint p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint bcd2int(input longint x, input int nd);
        longint r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + ((x >> (4 * i)) & 15);
        return r;
    endfunction

    function automatic longint int2bcd(input longint v, input int nd);
        longint r = 0;
        longint t = v;
        for (int i = 0; i < nd; i++) begin
            r = r | ((t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[11:0], 4'($urandom_range(0, 9))};
        return r;
    endfunction

    task automatic model(input int w, input bit decen, input logic [3:0] o, input longint a,
                         input longint b, input bit ci, input bit vi, input bit d,
                         output longint f, output bit n, output bit v, output bit z,
                         output bit c, output int lat);
        longint m  = (longint'(1) << w) - 1;
        longint hi = longint'(1) << (w - 1);
        longint sa = (a >= hi) ? a - (m + 1) : a;
        longint sb = (b >= hi) ? b - (m + 1) : b;
        longint r, sr, p10;
        int     nd = w / 4;
        bit     dm = decen && d && (o <= 4'd1);
        p10 = pow10(nd);
        c = ci;
        v = vi;
        f = a;
        case (o)
            4'h0: begin
                r = a + b + ci;      f = r & m;  c = (r > m);
                sr = sa + sb + ci;   v = (sr > hi - 1) || (sr < -hi);
                if (dm) begin
                    r = bcd2int(a, nd) + bcd2int(b, nd) + ci;
                    c = (r >= p10);
                    f = int2bcd(r % p10, nd);
                end
            end
            4'h1: begin
                r = a - b - (1 - ci); f = r & m;  c = (r >= 0);
                sr = sa - sb - (1 - ci); v = (sr > hi - 1) || (sr < -hi);
                if (dm) begin
                    r = bcd2int(a, nd) - bcd2int(b, nd) - (1 - ci);
                    c = (r >= 0);
                    if (r < 0) r = r + p10;
                    f = int2bcd(r, nd);
                end
            end
            4'h2: f = a ^ b;
            4'h3: f = a | b;
            4'h4: f = a & b;
            4'h5: f = (a + 1) & m;
            4'h6: f = (a - 1) & m;
            4'h7: begin f = (longint'(ci) << (w - 1)) | (b >> 1); c = b[0]; end
            4'h8: begin f = ((b << 1) | longint'(ci)) & m; c = (b >> (w - 1)) & 1; end
            4'h9: begin f = (b << 1) & m; c = (b >> (w - 1)) & 1; end
            4'hA: begin f = b >> 1; c = b[0]; end
            4'hB: begin f = (a - b) & m; c = (a >= b); end
            default: begin f = a; c = 1'b0; end
        endcase
        n   = (f >> (w - 1)) & 1;
        z   = (f == 0);
        lat = dm ? 3 : 2;
    endtask

    // Latency counts the accept edge as edge 1; bounded to edge 6.
    task automatic collect();
        for (int i = 0; i < 3; i++) clat[i] = 0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (ov0 && clat[0] == 0) begin
                clat[0] = k; cf[0] = longint'(f0); cn[0] = n0; cvv[0] = v0; cz[0] = z0; cc[0] = c0;
            end
            if (ov1 && clat[1] == 0) begin
                clat[1] = k; cf[1] = longint'(f1); cn[1] = n1; cvv[1] = v1; cz[1] = z1; cc[1] = c1;
            end
            if (ov2 && clat[2] == 0) begin
                clat[2] = k; cf[2] = longint'(f2); cn[2] = n2; cvv[2] = v2; cz[2] = z2; cc[2] = c2;
            end
        end
    endtask

    task automatic verify(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic vi, input logic d);
        longint ef, m;
        bit     en, ev, ez, ec;
        int     el, w;
        for (int i = 0; i < 3; i++) begin
            w = (i == 1) ? 16 : 8;
            m = (longint'(1) << w) - 1;
            model(w, i != 2, o, longint'(x) & m, longint'(y) & m, ci, vi, d, ef, en, ev, ez, ec, el);
            check($sformatf("u%0d op%0h a=%0h b=%0h latency", i, o, x, y), clat[i], el);
            check($sformatf("u%0d op%0h a=%0h b=%0h f", i, o, x, y), cf[i], ef);
            check($sformatf("u%0d op%0h a=%0h b=%0h N", i, o, x, y), cn[i], en);
            check($sformatf("u%0d op%0h a=%0h b=%0h V", i, o, x, y), cvv[i], ev);
            check($sformatf("u%0d op%0h a=%0h b=%0h Z", i, o, x, y), cz[i], ez);
            check($sformatf("u%0d op%0h a=%0h b=%0h C", i, o, x, y), cc[i], ec);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic vi, input logic d);
        op_i = o; a_i = x; b_i = y; cin_i = ci; vin_i = vi; dec_i = d;
        in_valid = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic vi, input logic d);
        @(negedge clk);
        drive(o, x, y, ci, vi, d);
        #1;
        check("u0 in_ready idle", ir0, 1);
        check("u1 in_ready idle", ir1, 1);
        check("u2 in_ready idle", ir2, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect();
        verify(o, x, y, ci, vi, d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  o;
        logic [15:0] x, y;
        logic        ci, vi, d;
        logic [7:0]  hold_f;
        logic [3:0]  hold_fl;

        #12;
        check("reset out_valid", ov0, 0);
        check("reset f", f0, 0);
        check("reset flags", {n0, v0, z0, c0}, 0);
        check("reset in_ready", ir0, 1);
        check("reset f16", f1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'h0, 16'h0050, 16'h0050, 0, 0, 0);
        check("adc50 f", cf[0], 'hA0);
        check("adc50 NVZC", {cn[0], cvv[0], cz[0], cc[0]}, 4'b1100);
        check("adc50 latency", clat[0], 2);

        do_op(4'h0, 16'h0058, 16'h0046, 1, 0, 1);
        check("dadc f", cf[0], 'h05);
        check("dadc C", cc[0], 1);
        check("dadc Z", cz[0], 0);
        check("dadc latency", clat[0], 3);
        do_op(4'h1, 16'h0012, 16'h0021, 1, 0, 1);
        check("dsbc f", cf[0], 'h91);
        check("dsbc C", cc[0], 0);

        // Backpressure, with a competing request held on in_valid the whole time.
        out_ready = 1'b0;
        @(negedge clk);
        drive(4'h0, 16'h1234, 16'h4321, 0, 1, 0);
        @(posedge clk);
        #1 drive(4'h3, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        collect();
        verify(4'h0, 16'h1234, 16'h4321, 0, 1, 0);
        hold_f  = f0;
        hold_fl = {n0, v0, z0, c0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold f", f0, hold_f);
            check("hold flags", {n0, v0, z0, c0}, hold_fl);
            check("hold out_valid", ov0, 1);
            check("hold in_ready", ir0, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drive(4'h2, 16'h0F0F, 16'hF0FF, 1, 0, 0);
        #1 check("release in_ready", ir0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect();
        verify(4'h2, 16'h0F0F, 16'hF0FF, 1, 0, 0);

        // Reset while the decimal instances sit in DADJ.
        @(negedge clk);
        drive(4'h0, 16'h0019, 16'h0028, 0, 1, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("dadj reset out_valid", ov0, 0);
        check("dadj reset f", f0, 0);
        check("dadj reset flags", {n0, v0, z0, c0}, 0);
        check("dadj reset f16", f1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h0, 16'h0027, 16'h0015, 0, 0, 1);

        do_op(4'h8, 16'h0000, 16'h8000, 0, 0, 0);
        check("rol16 f", cf[1], 0);
        check("rol16 C", cc[1], 1);
        check("rol16 Z", cz[1], 1);
        do_op(4'hB, 16'h0010, 16'h0020, 0, 1, 0);
        check("cmp16 f", cf[1], 'hFFF0);
        check("cmp16 C", cc[1], 0);
        check("cmp16 N", cn[1], 1);
        check("cmp16 V", cvv[1], 1);

        do_op(4'h0, 16'h0009, 16'h0001, 0, 0, 1);
        check("nodec f", cf[2], 'h0A);
        check("nodec latency", clat[2], 2);
        do_op(4'hE, 16'h007F, 16'h0000, 1, 0, 0);
        check("pass f", cf[2], 'h7F);
        check("pass C", cc[2], 0);

        for (int it = 0; it < 200; it++) begin
            o  = 4'($urandom_range(0, 15));
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            vi = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            if (d && o <= 4'd1) begin
                x = rand_bcd();
                y = rand_bcd();
            end
            do_op(o, x, y, ci, vi, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
